// File: rtl/wb_axis_out_fifo.sv
`timescale 1ns/1ps
// AXI-Stream sink FIFO drained over Wishbone: a DATA register pops the FIFO head and
// a STATUS/CLEAR register reports occupancy and frame state.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no access in flight; decode a new Wishbone request
// POP_WAIT | DATA read pending; ack and pop once the FIFO holds a beat
// STAT     | STATUS read; ack with the status word
// CLR      | CLEAR write; ack and zero last_seen / beat_cnt
module wb_axis_out_fifo #(
   parameter int pDATA_WIDTH = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 5
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_dat_i,
   input  logic [31:0]            wbs_adr_i,
   output logic                   wbs_ack_o,
   output logic [31:0]            wbs_dat_o,
   input  logic                   sm_tvalid,
   input  logic [pDATA_WIDTH-1:0] sm_tdata,
   input  logic                   sm_tlast,
   output logic                   sm_tready
);
   localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, POP_WAIT, STAT, CLR} state_t;
   state_t state, state_nxt;

   logic [pDATA_WIDTH:0] mem [FIFO_DEPTH];
   logic [pDATA_WIDTH:0] head;
   logic [PTR_W-1:0]     rd_ptr, wr_ptr;
   logic [CNT_W-1:0]     count;
   logic                 last_seen;
   logic [15:0]          beat_cnt;
   logic                 hit, rd_data, rd_stat, wr_clr;
   logic                 full, empty, push, pop, clr;
   logic                 unused_ok;

   assign unused_ok = ^{wbs_sel_i, wbs_dat_i};

   assign hit     = (wbs_adr_i[31:24] == 8'h30) & wbs_stb_i & wbs_cyc_i;
   assign rd_data = hit & ~wbs_we_i & (wbs_adr_i[23:0] == 24'h00_0084);
   assign rd_stat = hit & ~wbs_we_i & (wbs_adr_i[23:0] == 24'h00_008C);
   assign wr_clr  = hit &  wbs_we_i & (wbs_adr_i[23:0] == 24'h00_008C);

   assign full      = (count == DEPTH_C);
   assign empty     = (count == '0);
   assign sm_tready = ~full & ~wb_rst_i;
   assign push      = sm_tvalid & sm_tready;
   assign head      = mem[rd_ptr];

   always_comb begin
      state_nxt = state;
      wbs_ack_o = 1'b0;
      wbs_dat_o = '0;
      pop       = 1'b0;
      clr       = 1'b0;
      case (state)
         IDLE: begin
            if (rd_data)      state_nxt = POP_WAIT;
            else if (rd_stat) state_nxt = STAT;
            else if (wr_clr)  state_nxt = CLR;
         end
         POP_WAIT: begin
            // count is registered, so a beat pushed this cycle is only visible next cycle
            if (!(wbs_stb_i & wbs_cyc_i)) begin
               state_nxt = IDLE;
            end else if (!empty) begin
               wbs_ack_o = 1'b1;
               wbs_dat_o = 32'(head[pDATA_WIDTH-1:0]);
               pop       = 1'b1;
               state_nxt = IDLE;
            end
         end
         STAT: begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = {beat_cnt, 8'(count), 4'b0000, last_seen,
                         head[pDATA_WIDTH] & ~empty, full, empty};
            state_nxt = IDLE;
         end
         CLR: begin
            wbs_ack_o = 1'b1;
            clr       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (wb_rst_i) begin
         wbs_ack_o = 1'b0;
         wbs_dat_o = '0;
         pop       = 1'b0;
         clr       = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         last_seen <= 1'b0;
         beat_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // a push in the same cycle as CLEAR takes precedence
         if (push & sm_tlast) last_seen <= 1'b1;
         else if (clr)        last_seen <= 1'b0;
         if (clr)       beat_cnt <= {15'd0, push};
         else if (push) beat_cnt <= beat_cnt + 16'd1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= {sm_tlast, sm_tdata};
   end
endmodule

// File: tb/tb_wb_axis_out_fifo.sv
`timescale 1ns/1ps
// Self-checking bench: queue-based FIFO/status model plus a bus-level ack expectation,
// one task per scenario.
module tb_wb_axis_out_fifo;
   localparam int          DEPTH  = 8;
   localparam logic [31:0] A_DATA = 32'h3000_0084;
   localparam logic [31:0] A_STAT = 32'h3000_008C;
   typedef enum int {OP_NONE, OP_DATA, OP_STAT, OP_CLR} op_t;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i, wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        sm_tvalid, sm_tlast, sm_tready;
   logic [31:0] sm_tdata;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_axis_out_fifo #(.pDATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .CNT_W(5)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
      .sm_tready(sm_tready)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [32:0] q[$];
   logic [32:0] src_q[$];
   int          src_delay  = 0;
   bit          rand_valid = 0;
   logic        last_seen_m = 1'b0;
   logic [15:0] beat_cnt_m  = 16'd0;
   op_t         bus_op   = OP_NONE;
   int          bus_wait = 0;
   bit          bus_done = 0;
   logic [31:0] bus_rdata;

   function automatic logic [31:0] model_status();
      logic hd_last;
      hd_last = (q.size() > 0) ? q[0][32] : 1'b0;
      return {beat_cnt_m, 8'(q.size()), 4'b0000, last_seen_m, hd_last,
              q.size() == DEPTH, q.size() == 0};
   endfunction

   // One clock: drive stream source, check outputs at negedge, advance model at posedge.
   task automatic cycle();
      logic        exp_tready, exp_ack, push;
      logic [31:0] exp_dat;
      logic [32:0] beat;
      if (src_delay > 0) begin
         src_delay--;
         sm_tvalid = 1'b0;
      end else if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
         beat      = src_q[0];
         sm_tvalid = 1'b1;
         sm_tlast  = beat[32];
         sm_tdata  = beat[31:0];
      end else begin
         sm_tvalid = 1'b0;
      end
      if (!sm_tvalid) begin
         sm_tdata = $urandom;
         sm_tlast = 1'($urandom);
      end
      @(negedge wb_clk_i);
      exp_tready = !wb_rst_i && (q.size() < DEPTH);
      push       = sm_tvalid && exp_tready;
      exp_ack    = 1'b0;
      exp_dat    = '0;
      if (!wb_rst_i && bus_op != OP_NONE && bus_wait > 0) begin
         case (bus_op)
            OP_DATA: if (q.size() > 0) begin exp_ack = 1'b1; exp_dat = q[0][31:0]; end
            OP_STAT: begin exp_ack = 1'b1; exp_dat = model_status(); end
            OP_CLR:  exp_ack = 1'b1;
            default: exp_ack = 1'b0;
         endcase
      end
      n_checks++;
      if (sm_tready !== exp_tready) begin
         n_fail++;
         $display("FAIL tready t=%0t: got %b expected %b", $time, sm_tready, exp_tready);
      end
      n_checks++;
      if (wbs_ack_o !== exp_ack) begin
         n_fail++;
         $display("FAIL ack t=%0t: got %b expected %b", $time, wbs_ack_o, exp_ack);
      end
      n_checks++;
      if (wbs_dat_o !== exp_dat) begin
         n_fail++;
         $display("FAIL dat t=%0t: got %h expected %h", $time, wbs_dat_o, exp_dat);
      end
      if (wbs_ack_o === 1'b1) bus_rdata = wbs_dat_o;
      @(posedge wb_clk_i);
      if (wb_rst_i) begin
         q.delete();
         last_seen_m = 1'b0;
         beat_cnt_m  = 16'd0;
      end else begin
         if (exp_ack) begin
            if (bus_op == OP_DATA) void'(q.pop_front());
            if (bus_op == OP_CLR) begin last_seen_m = 1'b0; beat_cnt_m = 16'd0; end
            bus_done = 1;
         end
         if (push) begin
            q.push_back({sm_tlast, sm_tdata});
            beat_cnt_m++;
            if (sm_tlast) last_seen_m = 1'b1;
            void'(src_q.pop_front());
         end
      end
      if (bus_op != OP_NONE) bus_wait++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic bus(input op_t op, input int budget, output logic [31:0] rdata, output int lat);
      int n;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      wbs_we_i  = (op == OP_CLR);
      wbs_adr_i = (op == OP_DATA) ? A_DATA : A_STAT;
      wbs_dat_i = $urandom;
      bus_op = op; bus_wait = 0; bus_done = 0; bus_rdata = '0;
      n = 0;
      while (!bus_done && n < budget) begin cycle(); n++; end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      bus_op = OP_NONE;
      rdata  = bus_rdata;
      lat    = bus_done ? bus_wait - 1 : -1;
      n_checks++;
      if (!bus_done) begin
         n_fail++;
         $display("FAIL bus_timeout op=%0d: no ack after %0d cycles, expected one", op, budget);
      end
   endtask

   task automatic wait_src(input int budget);
      int n = 0;
      while (src_q.size() > 0 && n < budget) begin cycle(); n++; end
      n_checks++;
      if (src_q.size() != 0) begin
         n_fail++;
         $display("FAIL src_timeout: %0d beats left, expected 0", src_q.size());
      end
   endtask

   task automatic test_reset();
      logic [31:0] d; int lat;
      wb_rst_i = 1'b1;
      idle(3);
      wb_rst_i = 1'b0;
      idle(2);
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status: got %h expected 00000001", d); end
   endtask

   task automatic test_basic();
      logic [31:0] d; int lat;
      logic [31:0] exp_d [3] = '{32'h11, 32'h22, 32'h33};
      src_q = '{{1'b0, 32'h11}, {1'b0, 32'h22}, {1'b1, 32'h33}};
      wait_src(20);
      for (int i = 0; i < 3; i++) begin
         bus(OP_DATA, 10, d, lat);
         n_checks++;
         if (d !== exp_d[i]) begin n_fail++; $display("FAIL basic_data%0d: got %h expected %h", i, d, exp_d[i]); end
         n_checks++;
         if (lat != 1) begin n_fail++; $display("FAIL basic_lat%0d: got %0d expected 1", i, lat); end
      end
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d !== 32'h0003_0009) begin n_fail++; $display("FAIL basic_status: got %h expected 00030009", d); end
   endtask

   task automatic test_full();
      logic [31:0] d; int lat;
      logic [32:0] sent [9];
      for (int i = 0; i < 9; i++) begin
         sent[i] = {1'($urandom), 32'($urandom)};
         src_q.push_back(sent[i]);
      end
      rand_valid = 0;
      idle(12);
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d[1] !== 1'b1 || d[15:8] !== 8'd8) begin
         n_fail++; $display("FAIL full_status: got full=%b count=%0d expected full=1 count=8", d[1], d[15:8]);
      end
      bus(OP_DATA, 5, d, lat);
      n_checks++;
      if (d !== sent[0][31:0]) begin n_fail++; $display("FAIL full_pop: got %h expected %h", d, sent[0][31:0]); end
      idle(2);
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d[15:8] !== 8'd8) begin n_fail++; $display("FAIL full_refill: got count=%0d expected 8", d[15:8]); end
      for (int i = 1; i < 9; i++) begin
         bus(OP_DATA, 5, d, lat);
         n_checks++;
         if (d !== sent[i][31:0]) begin n_fail++; $display("FAIL full_drain%0d: got %h expected %h", i, d, sent[i][31:0]); end
      end
   endtask

   task automatic test_empty_read();
      logic [31:0] d; int lat;
      src_q = '{{1'b0, 32'h0000_ABCD}};
      src_delay = 5;
      bus(OP_DATA, 20, d, lat);
      n_checks++;
      if (d !== 32'h0000_ABCD) begin n_fail++; $display("FAIL stall_data: got %h expected 0000abcd", d); end
      n_checks++;
      if (lat != 6) begin n_fail++; $display("FAIL stall_lat: got %0d expected 6", lat); end
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d[15:8] !== 8'd0) begin n_fail++; $display("FAIL stall_count: got %0d expected 0", d[15:8]); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; int lat;
      logic [32:0] sent [64];
      bus(OP_CLR, 5, d, lat);
      for (int i = 0; i < 64; i++) begin
         sent[i] = {1'($urandom), 32'($urandom)};
         src_q.push_back(sent[i]);
      end
      rand_valid = 1;
      for (int i = 0; i < 64; i++) begin
         bus(OP_DATA, 50, d, lat);
         n_checks++;
         if (d !== sent[i][31:0]) begin n_fail++; $display("FAIL stream_data%0d: got %h expected %h", i, d, sent[i][31:0]); end
      end
      rand_valid = 0;
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d[31:16] !== 16'd64 || d[15:8] !== 8'd0) begin
         n_fail++; $display("FAIL stream_status: got beat_cnt=%0d count=%0d expected 64 and 0", d[31:16], d[15:8]);
      end
   endtask

   task automatic test_clear();
      logic [31:0] d; int lat;
      src_q = '{{1'b0, 32'hA1}, {1'b0, 32'hA2}, {1'b1, 32'hA3}};
      wait_src(20);
      bus(OP_CLR, 5, d, lat);
      n_checks++;
      if (lat != 1) begin n_fail++; $display("FAIL clr_lat: got %0d expected 1", lat); end
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d[3] !== 1'b0 || d[31:16] !== 16'd0 || d[15:8] !== 8'd3) begin
         n_fail++; $display("FAIL clr_status: got %h expected last_seen=0 beat_cnt=0 count=3", d);
      end
      for (int i = 0; i < 3; i++) begin
         bus(OP_DATA, 5, d, lat);
         n_checks++;
         if (d !== 32'hA1 + 32'(i)) begin n_fail++; $display("FAIL clr_data%0d: got %h expected %h", i, d, 32'hA1 + 32'(i)); end
      end
      src_q = '{{1'b1, 32'h5A5A}};
      src_delay = 1;
      bus(OP_CLR, 5, d, lat);
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d[3] !== 1'b1 || d[31:16] !== 16'd1) begin
         n_fail++; $display("FAIL clr_push: got last_seen=%b beat_cnt=%0d expected 1 and 1", d[3], d[31:16]);
      end
      bus(OP_DATA, 5, d, lat);
      n_checks++;
      if (d !== 32'h5A5A) begin n_fail++; $display("FAIL clr_push_data: got %h expected 00005a5a", d); end
   endtask

   task automatic test_unclaimed();
      logic [31:0] d; int lat;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      wbs_we_i = 1'b1; wbs_adr_i = A_DATA;
      idle(4);
      wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0090;
      idle(3);
      wbs_adr_i = 32'h2000_008C;
      idle(3);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (lat != 1) begin n_fail++; $display("FAIL unclaimed_idle: got lat %0d expected 1", lat); end
   endtask

   task automatic test_abort();
      logic [31:0] d; int lat;
      src_q = '{{1'b0, 32'h77}};
      src_delay = 2;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
      idle(3);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      idle(2);
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d[15:8] !== 8'd1) begin n_fail++; $display("FAIL abort_count: got %0d expected 1", d[15:8]); end
      bus(OP_DATA, 5, d, lat);
      n_checks++;
      if (d !== 32'h77 || lat != 1) begin n_fail++; $display("FAIL abort_data: got %h lat %0d expected 00000077 lat 1", d, lat); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; int lat;
      for (int i = 0; i < 4; i++) src_q.push_back({1'b0, 32'($urandom)});
      wait_src(20);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
      idle(1);
      wb_rst_i = 1'b1;
      idle(1);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      idle(2);
      wb_rst_i = 1'b0;
      idle(1);
      bus(OP_STAT, 5, d, lat);
      n_checks++;
      if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL rstmid_status: got %h expected 00000001", d); end
   endtask

   initial begin
      wb_rst_i = 1'b1;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'hF; wbs_dat_i = '0; wbs_adr_i = '0;
      sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
      test_reset();
      test_basic();
      test_full();
      test_empty_read();
      test_back_to_back();
      test_clear();
      test_unclaimed();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end
endmodule

// File: doc/wb_axis_out_fifo.md
Name: wb_axis_out_fifo

Overview:
- Receive-side companion to the Wishbone-to-AXI-Stream input bridge.
- Acts as an AXI-Stream slave that accepts FIR output beats (data plus tlast) into a small FIFO.
- Exposes the FIFO to the Caravel Wishbone bus: a data-pop register and a status/clear register in the 0x30xx_xxxx user space.
- Firmware drains FIR results by polling status and reading the data register.

Parameters:
- pDATA_WIDTH, 32, width of the AXI-Stream data path and the FIFO entries.
- FIFO_DEPTH, 8, number of FIFO entries; power of two, 2..16.
- CNT_W, 5, width of the occupancy counter; must hold values 0..FIFO_DEPTH.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects; ignored, full-word access only.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_adr_i  in  32  Wishbone address.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  Wishbone read data.
- sm_tvalid  in  1  AXI-Stream beat valid from FIR.
- sm_tdata  in  pDATA_WIDTH  AXI-Stream data.
- sm_tlast  in  1  AXI-Stream last beat of frame.
- sm_tready  out  1  AXI-Stream ready back to FIR.

Behaviour:
- Clocking and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE; count = 0; read and write pointers = 0.
  - last_seen = 0; beat_cnt = 0.
  - wbs_ack_o = 0; wbs_dat_o = 0.
  - sm_tready = 0 while wb_rst_i is high.
- Address decode: hit = wbs_adr_i[31:24]==8'h30 & wbs_stb_i & wbs_cyc_i.
  - 0x84, read: DATA, pops the FIFO head.
  - 0x8C, read: STATUS.
  - 0x8C, write: CLEAR.
  - Any other offset, or a write to 0x84, is not claimed and gets no ack.
- FIFO:
  - Each entry stores {tlast, tdata}.
  - sm_tready = ~full & ~wb_rst_i, where full = (count==FIFO_DEPTH).
  - A push occurs on any cycle with sm_tvalid & sm_tready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: both are performed and count is unchanged.
  - When not full, a push is never lost.
- FSM states:
  - IDLE: read 0x84 -> POP_WAIT; read 0x8C -> STAT; write 0x8C -> CLR; otherwise stay in IDLE. ack = 0.
  - POP_WAIT:
    - If count>0: ack = 1 (combinational from state), wbs_dat_o = head tdata, head popped at the clock edge, next state IDLE.
    - If count==0: ack = 0 and stay, stalling the bus until data arrives.
    - No same-cycle bypass: a beat pushed in cycle N can first be acked in cycle N+1.
  - STAT: ack = 1 and next state IDLE. wbs_dat_o fields:
    - [0] empty
    - [1] full
    - [2] head tlast (0 if empty)
    - [3] last_seen
    - [7:4] 0
    - [15:8] count, zero-extended
    - [31:16] beat_cnt
  - CLR: ack = 1, last_seen <= 0, beat_cnt <= 0, next state IDLE. FIFO contents are not touched.
- wbs_dat_o is 0 whenever ack = 0, and also for the CLR ack.
- Ack latency: DATA has 1 cycle minimum (request seen in IDLE, ack in the next cycle). STAT and CLR always ack in exactly 1 cycle.
- Master behaviour: the master drops stb after the ack cycle. IDLE issues no ack, so a single access is never double-acked.
- last_seen is set on a push with sm_tlast=1 and stays set until CLR. If the push and the CLR happen in the same cycle, the set wins.
- beat_cnt:
  - 16 bits; increments on every push and wraps 0xFFFF -> 0.
  - If a CLR and a push happen in the same cycle, the result is 1.
- Reset mid-access: FSM returns to IDLE, the FIFO is emptied, and no ack is issued.
- Master abort in POP_WAIT (stb or cyc dropped): return to IDLE, no pop, no ack.

Test Plan:
- Push 3 beats 0x11, 0x22, 0x33 (tlast on 0x33), then read 0x30000084 three times -> acks each one cycle after request, data 0x11, 0x22, 0x33, in order. Then STATUS = 0x0000_0000 | last_seen(0x8) | beat_cnt 3 << 16 = 0x0003_0009 (empty=1).
- Fill 8 beats with sm_tvalid held high -> sm_tready drops after 8th accept, STATUS[1]=1 and count=8. One DATA read -> sm_tready rises the next cycle, the 9th beat is accepted, count returns to 8.
- DATA read on empty FIFO, then one beat 0xABCD pushed 5 cycles later -> ack held low until the cycle after the push, returns 0xABCD, count 0 afterwards.
- Continuous streaming with a DATA read completing in the same cycle as a push -> count unchanged, no beat dropped or duplicated over 64 beats, beat_cnt = 64.
- Write 0x3000008C after frames with tlast -> last_seen = 0 and beat_cnt = 0, FIFO data still readable. Then CLR in the same cycle as a tlast push -> last_seen = 1 and beat_cnt = 1.
- Assert wb_rst_i during POP_WAIT with 4 entries queued -> no ack, STATUS afterwards reads 0x0000_0001, sm_tready = 0 during reset and 1 after.
